// File: rtl/data_decoder_pkg.sv
// ----------------------------------------------------------------------------
// data_code_pkg
//   Shared definitions for consumers of the up/down counter output word.
//   - encoding names accepted by the Signed parameter
//   - FSM state type of the data_decoder conversion engine
//   - add-3 digit correction used by the double-dabble shifter
//   - min_digits(): decimal digits needed to show any Size-bit magnitude
//   Related configuration macro: DATA_DECODER_AUTO_START_EN (used in data_decoder).
// ----------------------------------------------------------------------------
package data_code_pkg;

    localparam string CODE_UNSIGNED  = "No";
    localparam string CODE_SIGN_MAG  = "Yes";
    localparam string CODE_ONES_COMP = "Reverse";
    localparam string CODE_TWOS_COMP = "Additional";

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A BCD digit of 5 or more would exceed 9 after doubling; adding 3
    // first makes the following shift carry correctly into the next digit.
    function automatic logic [3:0] add3_digit(input logic [3:0] digit);
        return (digit >= 4'd5) ? digit + 4'd3 : digit;
    endfunction

    // Smallest digit count whose range 0..10^n-1 covers 0..2^size-1.
    function automatic int min_digits(input int size);
        int n;
        int lim;
        int top;
        n   = 1;
        lim = 10;
        top = (1 << size) - 1;
        while (top >= lim) begin
            n   = n + 1;
            lim = lim * 10;
        end
        return n;
    endfunction

endpackage

// File: rtl/data_decoder_if.sv
// ----------------------------------------------------------------------------
// data_decoder_if
//   Bundle between the counter-side producer and data_decoder.
//   Handshake: the producer raises Start (sampled on the rising clock edge)
//   with Data valid in the same cycle; the request is taken only while
//   Busy=0 and is never queued. Valid is a one-cycle pulse marking the cycle
//   in which Negative/Bcd/Overflow first show a new result; they hold until
//   the next result.
//   Signals:
//     Data      producer -> decoder  Size bits, coded counter word
//     Start     producer -> decoder  conversion request
//     Busy      decoder -> producer  conversion in progress
//     Valid     decoder -> producer  result-update pulse
//     Negative  decoder -> producer  sign of last result
//     Bcd       decoder -> producer  4*Digits packed BCD, digit 0 in [3:0]
//     Overflow  decoder -> producer  magnitude exceeded 10^Digits-1
//     dbg_state decoder -> observer  current FSM state
// ----------------------------------------------------------------------------
interface data_decoder_if
    import data_code_pkg::*;
#(
    parameter int Size   = 5,
    parameter int Digits = 2
);
    logic [Size-1:0]     Data;
    logic                Start;
    logic                Busy;
    logic                Valid;
    logic                Negative;
    logic [4*Digits-1:0] Bcd;
    logic                Overflow;
    state_t              dbg_state;

    modport master (
        output Data, Start,
        input  Busy, Valid, Negative, Bcd, Overflow, dbg_state
    );

    modport slave (
        input  Data, Start,
        output Busy, Valid, Negative, Bcd, Overflow, dbg_state
    );
endinterface

// File: rtl/data_decoder_code_decode.sv
// ----------------------------------------------------------------------------
// code_decode
//   Combinational decode of a counter word into sign and magnitude.
//   Parameters: Size (word width), Signed (encoding name, see data_code_pkg).
//   Ports:
//     Data      in  Size  coded word
//     Negative  out 1     sign; negative zero encodings report +0
//     Mag       out Size  magnitude; two's complement 10..0 keeps 2^(Size-1)
// ----------------------------------------------------------------------------
module code_decode
    import data_code_pkg::*;
#(
    parameter int    Size   = 5,
    parameter string Signed = "No"
) (
    input  logic [Size-1:0] Data,
    output logic            Negative,
    output logic [Size-1:0] Mag
);
    generate
        if (Signed == CODE_UNSIGNED) begin : g_unsigned
            assign Negative = 1'b0;
            assign Mag      = Data;
        end else if (Signed == CODE_SIGN_MAG) begin : g_sign_mag
            assign Mag      = {1'b0, Data[Size-2:0]};
            assign Negative = Data[Size-1] & (|Data[Size-2:0]);
        end else if (Signed == CODE_ONES_COMP) begin : g_ones
            // All-ones is negative zero; inverting it gives 0, so the sign drops.
            assign Mag      = Data[Size-1] ? ~Data : Data;
            assign Negative = Data[Size-1] & (|Mag);
        end else if (Signed == CODE_TWOS_COMP) begin : g_twos
            // 10..0 negates to itself, which read unsigned is exactly 2^(Size-1).
            assign Mag      = Data[Size-1] ? (~Data + Size'(1)) : Data;
            assign Negative = Data[Size-1];
        end else begin : g_bad_code
            $error("code_decode: Signed must be No, Yes, Reverse or Additional");
            assign Negative = 1'b0;
            assign Mag      = Data;
        end
    endgenerate
endmodule

// File: rtl/data_decoder.sv
// ----------------------------------------------------------------------------
// data_decoder
//   Converts a coded counter word to sign + packed BCD with a one-bit-per-clock
//   double-dabble engine and a Start/Busy/Valid handshake.
//   Parameters: Size (2..16), Signed (No/Yes/Reverse/Additional), Digits.
//   Ports:
//     Clock  in  rising-edge clock
//     Reset  in  synchronous, active-low reset (wins over Start)
//     bus    data_decoder_if.slave: Data, Start in; Busy, Valid, Negative,
//            Bcd, Overflow, dbg_state out
//   Macro DATA_DECODER_AUTO_START_EN: when defined, a change of Data relative
//   to the last accepted word also starts a conversion while idle.
//   Timing: accept at edge N, shifts at N+1..N+Size, results at N+Size+1.
// ----------------------------------------------------------------------------
module data_decoder
    import data_code_pkg::*;
#(
    parameter int    Size   = 5,
    parameter string Signed = "No",
    parameter int    Digits = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    data_decoder_if.slave bus
);
    localparam int CW = $clog2(Size + 1);
    localparam int BW = 4 * Digits;
    // With too few digits some magnitudes cannot be shown; those saturate.
    localparam bit CAN_OVF = (Digits < min_digits(Size));
    localparam int unsigned MAX_BCD = CAN_OVF ? int'(10 ** Digits - 1) : 0;

    generate
        if (Size < 2 || Size > 16) begin : g_bad_size
            $error("data_decoder: Size must be in 2..16");
        end
        if (Digits < 1) begin : g_bad_digits
            $error("data_decoder: Digits must be at least 1");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [Size-1:0] mag_q;
    logic [BW-1:0]   scr_q;
    logic [BW-1:0]   scr_adj;
    logic            neg_lat_q;
    logic            ovf_lat_q;
    logic            valid_q;
    logic            neg_q;
    logic            ovf_q;
    logic [BW-1:0]   bcd_q;
    logic            dec_neg;
    logic [Size-1:0] dec_mag;
    logic            trig;
    logic            accept;
    logic            do_shift;
    logic            do_done;

    code_decode #(
        .Size   (Size),
        .Signed (Signed)
    ) u_decode (
        .Data     (bus.Data),
        .Negative (dec_neg),
        .Mag      (dec_mag)
    );

`ifdef DATA_DECODER_AUTO_START_EN
    logic [Size-1:0] last_q;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            last_q <= '0;
        end else if (accept) begin
            last_q <= bus.Data;
        end
    end

    assign trig = bus.Start | (bus.Data != last_q);
`else
    assign trig = bus.Start;
`endif

    // State register
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        do_shift = 1'b0;
        do_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                do_shift = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                do_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        scr_adj = scr_q;
        for (int d = 0; d < Digits; d++) begin
            scr_adj[4*d +: 4] = add3_digit(scr_q[4*d +: 4]);
        end
    end

    // Conversion datapath: the overflow decision is taken on the unshifted
    // magnitude at acceptance, since the shifter consumes it bit by bit.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt_q     <= '0;
            mag_q     <= '0;
            scr_q     <= '0;
            neg_lat_q <= 1'b0;
            ovf_lat_q <= 1'b0;
        end else if (accept) begin
            cnt_q     <= CW'(Size);
            mag_q     <= dec_mag;
            scr_q     <= '0;
            neg_lat_q <= dec_neg;
            ovf_lat_q <= CAN_OVF && (32'(dec_mag) > MAX_BCD);
        end else if (do_shift) begin
            // Top scratch bit falls off; only matters when saturating anyway.
            scr_q <= BW'({scr_adj, mag_q[Size-1]});
            mag_q <= {mag_q[Size-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Result registers
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            valid_q <= do_done;
            if (do_done) begin
                neg_q <= neg_lat_q;
                ovf_q <= ovf_lat_q;
                bcd_q <= ovf_lat_q ? {Digits{4'h9}} : scr_q;
            end
        end
    end

    assign bus.Busy      = (state_q != ST_IDLE);
    assign bus.Valid     = valid_q;
    assign bus.Negative  = neg_q;
    assign bus.Overflow  = ovf_q;
    assign bus.Bcd       = bcd_q;
    assign bus.dbg_state = state_q;

endmodule
